md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline, alongside the ALU.
- Executes mult/multu/div/divu and mthi/mtlo, and holds the architectural HI/LO registers.
- Exposes a busy indication to the hazard unit, which stalls mfhi/mflo/md instructions in D while an operation is in flight.
- HI/LO values read in E are forwarded to the M-stage result path by the surrounding pipeline, not by this block.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub when enabled); must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an md op; valid for one cycle per instruction.
- md_op  in  4  operation code from the shared package; sampled only when start=1.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- busy  out  1  operation in flight.
- md_stall  out  1  start | busy, combinational; consumed by the hazard unit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: hi=0, lo=0, busy=0, counter=0, pending result=0. Reset mid-operation aborts the operation and nothing is committed.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter active).
- IDLE → RUN: on start with op in {MULT, MULTU, DIV, DIVU, MADD, MSUB}.
  - Operands and op are latched at edge T.
  - Counter loads MULT_CYCLES-1 or DIV_CYCLES-1.
  - busy is high for cycles T+1 … T+N.
- RUN → IDLE: at the edge where counter==0. Commit happens on that same edge; new hi/lo are visible in the first cycle that busy=0. Before commit, hi/lo keep their old values.
- MTHI/MTLO: single-cycle. hi (or lo) ← a at edge T; busy stays 0; the other register is unchanged.
- MD_NONE, or start=0: no effect.
- start while busy=1: ignored (the hazard unit guarantees this never happens; an assertion flags it in simulation).
- mult: {hi,lo} ← signed(a) × signed(b), 64-bit. multu: the same, unsigned.
- div:
  - lo ← quotient truncated toward zero; hi ← remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Division by zero (b=0): full DIV_CYCLES busy, no commit; hi/lo unchanged.
- Latched operands are independent of a/b after edge T; later pipeline changes do not affect the result.
- hi/lo are registered outputs only; nothing combinational reaches them from a/b.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined:
  - md_op MADD: {hi,lo} ← {hi,lo} + signed(a)×signed(b), modulo 2^64.
  - md_op MSUB: {hi,lo} ← {hi,lo} − signed(a)×signed(b), modulo 2^64.
  - Both use MULT_CYCLES. The accumulator operand is the hi/lo value at commit time; because starts are not accepted while busy, this equals the value at start.
- When undefined: MADD/MSUB codes are treated as MD_NONE (no busy, no state change).

Decomposition:
- Shared package md_pkg holds:
  - md_op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MSUB=8.
  - Width constant MD_OP_W=4.
  - Default cycle-count constants.
- Control-decoder changes (md_op, start) belong to ctrl, not to this block.
- One natural sub-module: md_calc. It is purely combinational: it takes the latched op, operands and current {hi,lo}, and returns the 64-bit result plus a commit-enable (0 on divide by zero). md_unit keeps the FSM, counter and registers.

Test Plan:
- MULT a=0xFFFFFFFE (−2), b=3:
  - busy for exactly 5 cycles, md_stall=1 in the start cycle.
  - After busy falls: hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo keep their prior values throughout busy.
- DIVU a=100, b=7: 10 busy cycles, then lo=14, hi=2. DIV a=−7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22: 10 busy cycles, then hi=0x11, lo=0x22 unchanged. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF, then MTLO a=0x1234 on the next cycle: busy stays 0; hi=0xDEADBEEF after the first edge, lo=0x1234 after the second.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, with reset asserted in the 3rd busy cycle: next cycle busy=0, hi=lo=0, and no later commit.
- With MD_MADD_EN, from hi=0, lo=0xFFFFFFFF, MADD a=1, b=1: hi=1, lo=0. Without the macro, the same op leaves busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, widths and
// default cycle counts. The optional multiply-accumulate ops (MADD/MSUB)
// are enabled by defining MD_MADD_EN.
package md_pkg;

  localparam int unsigned MD_OP_W            = 4;
  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MSUB  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for several cycles and commit at the end.
  function automatic logic md_is_long(md_op_e op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MSUB);
`endif
    return r;
  endfunction

  // Long ops that use the divide latency.
  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result path of the multiply/divide unit. Produces the new
// {hi,lo} for the latched op and a commit enable (low on divide by zero).
// MADD/MSUB accumulate into the current {hi,lo} when MD_MADD_EN is defined.
module md_calc
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] res,
  output logic        commit
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sdiv;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;

  // Products, sign-magnitude division and op selection.
  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'b0, a} * {32'b0, b};

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of overflowing; quotient truncates toward zero and the
    // remainder follows the dividend's sign.
    sdiv    = (op == MD_DIV);
    mag_a   = (sdiv && a[31]) ? (32'd0 - a) : a;
    mag_b   = (sdiv && b[31]) ? (32'd0 - b) : b;
    divisor = (b == '0) ? 32'd1 : mag_b;
    quo_u   = mag_a / divisor;
    rem_u   = mag_a % divisor;
    quo     = (sdiv && (a[31] ^ b[31])) ? (32'd0 - quo_u) : quo_u;
    rem     = (sdiv && a[31]) ? (32'd0 - rem_u) : rem_u;

    res     = hilo;
    commit  = 1'b0;
    case (op)
      MD_MULT: begin
        res    = prod_s;
        commit = 1'b1;
      end
      MD_MULTU: begin
        res    = prod_u;
        commit = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        res    = {rem, quo};
        commit = (b != '0);
      end
`ifdef MD_MADD_EN
      MD_MADD: begin
        res    = hilo + prod_s;
        commit = 1'b1;
      end
      MD_MSUB: begin
        res    = hilo - prod_s;
        commit = 1'b1;
      end
`endif
      default: begin
        res    = hilo;
        commit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: holds architectural HI/LO, runs
// mult/multu/div/divu with a fixed-latency down-counter, and performs
// mthi/mtlo in a single cycle. MADD/MSUB are available when MD_MADD_EN
// is defined; otherwise those codes behave as MD_NONE.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic               busy,
  output logic               md_stall,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int unsigned MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;

  md_op_e           op_in;
  logic [63:0]      calc_res;
  logic             calc_we;

  assign op_in    = md_op_e'(md_op);
  assign busy     = busy_q;
  assign md_stall = start | busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  md_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hilo   ({hi_q, lo_q}),
    .res    (calc_res),
    .commit (calc_we)
  );

  // Next-state logic: accept ops in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (md_is_long(op_in)) begin
            state_d = MD_RUN;
            busy_d  = 1'b1;
            op_d    = op_in;
            a_d     = a;
            b_d     = b;
            cnt_d   = md_is_div(op_in) ? DIV_LOAD : MULT_LOAD;
          end else if (op_in == MD_MTHI) begin
            hi_d = a;
          end else if (op_in == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          busy_d  = 1'b0;
          if (calc_we) begin
            {hi_d, lo_d} = calc_res;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, latched operands and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // The hazard unit must never present a new op while one is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(start && busy_q));
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver pushes the expected HI/LO and
// busy length per op, and a monitor pops and compares at each completion.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    string       name;
    int unsigned cycles;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] prior_hi;
    logic [31:0] prior_lo;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mh;
  logic [31:0] ml;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds start for exactly one rising edge.
  task automatic issue(input string name, input md_op_e op, input logic [31:0] ia,
                       input logic [31:0] ib, input int unsigned cyc,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.name = name; e.cycles = cyc; e.hi = eh; e.lo = el;
    e.prior_hi = mh; e.prior_lo = ml;
    sb_q.push_back(e);
    mh = eh; ml = el;
    start = 1'b1; md_op = op; a = ia; b = ib;
    #1 chk({name, " stall_in_start"}, 64'(md_stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    md_op = 4'($urandom_range(0, 15));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: counts busy cycles, checks HI/LO hold, pops on completion.
  initial begin
    int unsigned bcnt;
    bit          prev_busy;
    bit          single;
    bit          hold_ok;
    exp_t        e;
    bcnt = 0; prev_busy = 0; single = 0; hold_ok = 1;
    forever begin
      @(negedge clk);
      #2;
      if (busy === 1'b1) begin
        bcnt++;
        if (sb_q.size() > 0 && (hi !== sb_q[0].prior_hi || lo !== sb_q[0].prior_lo)) hold_ok = 0;
      end else if (prev_busy || single) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: got hi=%h lo=%h expected none", hi, lo);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, " busy_cycles"}, 64'(bcnt), 64'(e.cycles));
          chk({e.name, " hi"}, 64'(hi), 64'(e.hi));
          chk({e.name, " lo"}, 64'(lo), 64'(e.lo));
          chk({e.name, " hold_during_busy"}, 64'(hold_ok), 64'd1);
        end
        bcnt = 0; hold_ok = 1;
      end
      if (!start) chk("md_stall_follows_busy", 64'(md_stall), 64'(busy));
      single    = start && (busy !== 1'b1) && !reset;
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; md_op = '0; a = '0; b = '0;
    mh = '0; ml = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(negedge clk);

    issue("mthi_setup", MD_MTHI, 32'hAAAA5555, 32'h0, 0, 32'hAAAA5555, 32'h0); drain();
    issue("mtlo_setup", MD_MTLO, 32'h13579BDF, 32'h0, 0, 32'hAAAA5555, 32'h13579BDF); drain();
    issue("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA); drain();
    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14); drain();
    issue("div_neg7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD); drain();
    issue("mthi_11", MD_MTHI, 32'h11, 32'h0, 0, 32'h11, 32'hFFFFFFFD); drain();
    issue("mtlo_22", MD_MTLO, 32'h22, 32'h0, 0, 32'h11, 32'h22); drain();
    issue("div_by_zero", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22); drain();
    issue("div_overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000); drain();
    issue("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001); drain();
    issue("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'd10, 10, 32'd5, 32'h19999999); drain();
    issue("none_op", MD_NONE, 32'h1, 32'h2, 0, 32'd5, 32'h19999999); drain();

    // Back-to-back single-cycle moves.
    issue("mthi_b2b", MD_MTHI, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 32'h19999999);
    issue("mtlo_b2b", MD_MTLO, 32'h1234, 32'h0, 0, 32'hDEADBEEF, 32'h1234);
    drain();

    // Reset in the third busy cycle aborts the multiply.
    issue("multu_abort", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    issue("after_abort", MD_NONE, 32'h0, 32'h0, 0, 32'h0, 32'h0); drain();

    // Multiply-accumulate codes.
    issue("mthi_0", MD_MTHI, 32'h0, 32'h0, 0, 32'h0, 32'h0); drain();
    issue("mtlo_ff", MD_MTLO, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 32'hFFFFFFFF); drain();
`ifdef MD_MADD_EN
    issue("madd_carry", MD_MADD, 32'd1, 32'd1, 5, 32'h1, 32'h0); drain();
    issue("msub_6", MD_MSUB, 32'd2, 32'd3, 5, 32'h0, 32'hFFFFFFFA); drain();
`else
    issue("madd_disabled", MD_MADD, 32'd1, 32'd1, 0, 32'h0, 32'hFFFFFFFF); drain();
    issue("msub_disabled", MD_MSUB, 32'd2, 32'd3, 0, 32'h0, 32'hFFFFFFFF); drain();
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
